bcd_counter_display: RTL and testbench

Parametrised multi-digit BCD up/down counter driving one 9-bit seven-segment code per digit. It is the generalised successor of the two-digit fixed-direction segment counter, with the following additions:
- configurable digit count, terminal value and tick period;
- up/down direction, pause, synchronous clear and parallel load;
- a wrap pulse.

It sits between the board clock and the segment pins. It replaces the derived-clock scheme with a single-clock design using an internal tick enable.

---
 rtl/bcd_seg_pkg.sv | 35 +++
 rtl/bcd_counter_display_if.sv | 28 ++
 rtl/bcd_digit.sv | 40 ++++
 rtl/bcd_counter_display.sv | 139 +++++++++++++
 tb/tb_bcd_counter_display.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/bcd_seg_pkg.sv
// Shared widths, seven-segment code table and the digit decoder used by the
// BCD counter/display block.
package bcd_seg_pkg;

  localparam int BCD_W = 4;
  localparam int SEG_W = 9;

  // Segment codes: bits[6:0] = g..a active-high, bit 7 = dp (off), bit 8 spare (0).
  // Index 0 is the code for digit 0.
  localparam logic [9:0][SEG_W-1:0] SEG_CODE = {
    9'h06F, 9'h07F, 9'h007, 9'h07D, 9'h06D,
    9'h066, 9'h04F, 9'h05B, 9'h006, 9'h03F
  };
  localparam logic [SEG_W-1:0] SEG_BLANK = 9'h000;

  // Decode one BCD nibble; non-decimal nibbles blank the digit.
  function automatic logic [SEG_W-1:0] seg_decode(input logic [BCD_W-1:0] d);
    logic [SEG_W-1:0] s;
    case (d)
      4'd0:    s = SEG_CODE[0];
      4'd1:    s = SEG_CODE[1];
      4'd2:    s = SEG_CODE[2];
      4'd3:    s = SEG_CODE[3];
      4'd4:    s = SEG_CODE[4];
      4'd5:    s = SEG_CODE[5];
      4'd6:    s = SEG_CODE[6];
      4'd7:    s = SEG_CODE[7];
      4'd8:    s = SEG_CODE[8];
      4'd9:    s = SEG_CODE[9];
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bcd_counter_display_if.sv
// Control/status bundle of the BCD counter: the controller (master) drives
// enable/direction/clear/load, the counter (slave) returns count, segments
// and the one-cycle event pulses.
interface bcd_counter_display_if #(
  parameter int DIGITS = 2
) ();

  logic                                  en;
  logic                                  dir;
  logic                                  clr;
  logic                                  load;
  logic [bcd_seg_pkg::BCD_W*DIGITS-1:0]  load_val;
  logic [bcd_seg_pkg::BCD_W*DIGITS-1:0]  count;
  logic [bcd_seg_pkg::SEG_W*DIGITS-1:0]  seg_led;
  logic                                  wrap;
  logic                                  load_err;

  modport master (
    output en, dir, clr, load, load_val,
    input  count, seg_led, wrap, load_err
  );

  modport slave (
    input  en, dir, clr, load, load_val,
    output count, seg_led, wrap, load_err
  );

endinterface

// File: rtl/bcd_digit.sv
// One decimal digit of the counter. Either loads a value outright (clear,
// load, terminal wrap) or steps by one when its carry/borrow input is set.
module bcd_digit
  import bcd_seg_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_set,
  input  logic [BCD_W-1:0] i_set_val,
  input  logic             i_step_up,
  input  logic             i_step_dn,
  input  logic             i_ci,
  output logic [BCD_W-1:0] o_q,
  output logic             o_co
);

  logic [BCD_W-1:0] r_q;
  logic             w_nine;
  logic             w_zero;

  assign w_nine = (r_q == 4'd9);
  assign w_zero = (r_q == 4'd0);

  // Carry out when rolling 9->0 upward, borrow out when rolling 0->9 downward.
  assign o_co = i_ci & ((i_step_up & w_nine) | (i_step_dn & w_zero));
  assign o_q  = r_q;

  // Digit register: set has priority over a carried step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_q <= '0;
    else if (i_set)
      r_q <= i_set_val;
    else if (i_ci & i_step_up)
      r_q <= w_nine ? 4'd0 : r_q + 4'd1;
    else if (i_ci & i_step_dn)
      r_q <= w_zero ? 4'd9 : r_q - 4'd1;
  end

endmodule

// File: rtl/bcd_counter_display.sv
// Multi-digit BCD up/down counter with seven-segment outputs. A single clock
// domain: the prescaler produces a one-cycle tick used as a clock enable.
module bcd_counter_display
  import bcd_seg_pkg::*;
#(
  parameter int                      DIGITS   = 2,
  parameter logic [4*DIGITS-1:0]     MAX_BCD  = {DIGITS{4'h9}},
  parameter int                      TICK_DIV = 6_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  bcd_counter_display_if.slave bus
);

  localparam int CW = BCD_W * DIGITS;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]                  r_pre;
  logic                           r_wrap;
  logic                           r_load_err;

  logic [DIGITS-1:0][BCD_W-1:0]   w_q;
  logic [CW-1:0]                  w_count;
  logic [DIGITS:0]                w_c;
  logic                           w_unused_co;
  logic [SEG_W*DIGITS-1:0]        w_seg;

  logic                           w_tick;
  logic                           w_nib_ok;
  logic                           w_load_ok;
  logic                           w_at_max;
  logic                           w_at_zero;

  logic                           w_set;
  logic [CW-1:0]                  w_set_val;
  logic                           w_step_up;
  logic                           w_step_dn;
  logic                           w_wrap_nx;
  logic                           w_err_nx;

  assign w_count   = w_q;
  assign w_tick    = bus.en & (r_pre == PRE_LAST);
  assign w_at_max  = (w_count == MAX_BCD);
  assign w_at_zero = (w_count == '0);

  // Load is legal only if every nibble is decimal and the value fits the range.
  always_comb begin
    w_nib_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++)
      if (bus.load_val[i*BCD_W +: BCD_W] > 4'd9) w_nib_ok = 1'b0;
  end
  assign w_load_ok = w_nib_ok & (bus.load_val <= MAX_BCD);

  // Per-cycle priority: clear, then load, then tick step, else hold.
  always_comb begin
    w_set     = 1'b0;
    w_set_val = '0;
    w_step_up = 1'b0;
    w_step_dn = 1'b0;
    w_wrap_nx = 1'b0;
    w_err_nx  = 1'b0;
    if (bus.clr) begin
      w_set = 1'b1;
    end else if (bus.load) begin
      if (w_load_ok) begin
        w_set     = 1'b1;
        w_set_val = bus.load_val;
      end else begin
        w_err_nx  = 1'b1;
      end
    end else if (w_tick) begin
      if (bus.dir) begin
        if (w_at_max) begin
          w_set     = 1'b1;
          w_wrap_nx = 1'b1;
        end else begin
          w_step_up = 1'b1;
        end
      end else begin
        if (w_at_zero) begin
          w_set     = 1'b1;
          w_set_val = MAX_BCD;
          w_wrap_nx = 1'b1;
        end else begin
          w_step_dn = 1'b1;
        end
      end
    end
  end

  // Prescaler: restarts on clear/accepted load, otherwise runs only while enabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_pre <= '0;
    else if (bus.clr | (bus.load & w_load_ok))
      r_pre <= '0;
    else if (bus.en)
      r_pre <= (r_pre == PRE_LAST) ? '0 : r_pre + PW'(1);
  end

  // Event pulses line up with the cycle the new count becomes visible.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_wrap     <= w_wrap_nx;
      r_load_err <= w_err_nx;
    end
  end

  // Digit 0 always sees carry-in so a step starts at the least significant digit.
  assign w_c[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    bcd_digit u_dig (
      .clk       (clk),
      .rst       (rst),
      .i_set     (w_set),
      .i_set_val (w_set_val[i*BCD_W +: BCD_W]),
      .i_step_up (w_step_up),
      .i_step_dn (w_step_dn),
      .i_ci      (w_c[i]),
      .o_q       (w_q[i]),
      .o_co      (w_c[i+1])
    );
    assign w_seg[i*SEG_W +: SEG_W] = seg_decode(w_q[i]);
  end

  // Carry out of the top digit never matters: terminal wraps bypass the chain.
  assign w_unused_co = w_c[DIGITS];

  assign bus.count    = w_count;
  assign bus.seg_led  = w_seg;
  assign bus.wrap     = r_wrap;
  assign bus.load_err = r_load_err;

endmodule

// File: tb/tb_bcd_counter_display.sv
// Directed bench: a per-cycle vector table on a TICK_DIV=1 instance plus
// hand-written multi-cycle sequences on TICK_DIV=4 instances.
module tb_bcd_counter_display;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bcd_counter_display_if #(.DIGITS(2)) ifa ();
  bcd_counter_display_if #(.DIGITS(2)) ifb ();
  bcd_counter_display_if #(.DIGITS(2)) ifc ();

  bcd_counter_display #(.DIGITS(2), .MAX_BCD(8'h99), .TICK_DIV(4)) u_a (
    .clk(clk), .rst(rst_n), .bus(ifa));
  bcd_counter_display #(.DIGITS(2), .MAX_BCD(8'h59), .TICK_DIV(4)) u_b (
    .clk(clk), .rst(rst_n), .bus(ifb));
  bcd_counter_display #(.DIGITS(2), .MAX_BCD(8'h99), .TICK_DIV(1)) u_c (
    .clk(clk), .rst(rst_n), .bus(ifc));

  typedef struct {
    logic [3:0] ctl;     // {en, dir, clr, load}
    logic [7:0] lv;
    logic [7:0] ecount;
    logic [1:0] ev;      // {wrap, load_err}
  } vec_t;

  vec_t tv [16];

  function automatic vec_t mk(input logic [3:0] c, input logic [7:0] l,
                              input logic [7:0] e, input logic [1:0] f);
    vec_t v;
    v.ctl = c; v.lv = l; v.ecount = e; v.ev = f;
    return v;
  endfunction

  function automatic logic [8:0] ref_seg(input logic [3:0] d);
    case (d)
      4'd0: return 9'h03F; 4'd1: return 9'h006; 4'd2: return 9'h05B;
      4'd3: return 9'h04F; 4'd4: return 9'h066; 4'd5: return 9'h06D;
      4'd6: return 9'h07D; 4'd7: return 9'h007; 4'd8: return 9'h07F;
      4'd9: return 9'h06F; default: return 9'h000;
    endcase
  endfunction

  function automatic logic [17:0] ref_seg2(input logic [7:0] c);
    return {ref_seg(c[7:4]), ref_seg(c[3:0])};
  endfunction

  function automatic logic [7:0] to_bcd(input int k);
    return 8'(((k / 10) * 16) + (k % 10));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    ifa.en = 0; ifa.dir = 0; ifa.clr = 0; ifa.load = 0; ifa.load_val = '0;
    ifb.en = 0; ifb.dir = 0; ifb.clr = 0; ifb.load = 0; ifb.load_val = '0;
    ifc.en = 0; ifc.dir = 0; ifc.clr = 0; ifc.load = 0; ifc.load_val = '0;

    tv[0]  = mk(4'b1100, 8'h00, 8'h01, 2'b00);
    tv[1]  = mk(4'b1100, 8'h00, 8'h02, 2'b00);
    tv[2]  = mk(4'b0001, 8'h47, 8'h47, 2'b00);
    tv[3]  = mk(4'b0001, 8'h4A, 8'h47, 2'b01);
    tv[4]  = mk(4'b1000, 8'h00, 8'h46, 2'b00);
    tv[5]  = mk(4'b0000, 8'h00, 8'h46, 2'b00);
    tv[6]  = mk(4'b0001, 8'h09, 8'h09, 2'b00);
    tv[7]  = mk(4'b1100, 8'h00, 8'h10, 2'b00);
    tv[8]  = mk(4'b1000, 8'h00, 8'h09, 2'b00);
    tv[9]  = mk(4'b0010, 8'h00, 8'h00, 2'b00);
    tv[10] = mk(4'b1000, 8'h00, 8'h99, 2'b10);
    tv[11] = mk(4'b1100, 8'h00, 8'h00, 2'b10);
    tv[12] = mk(4'b1101, 8'h99, 8'h99, 2'b00);
    tv[13] = mk(4'b1101, 8'h9F, 8'h99, 2'b01);
    tv[14] = mk(4'b1011, 8'h47, 8'h00, 2'b00);
    tv[15] = mk(4'b1100, 8'h00, 8'h01, 2'b00);

    // Reset state
    repeat (2) edge1();
    chk("rst_count", 32'(ifa.count), 32'h00);
    chk("rst_seg",   32'(ifa.seg_led), 32'({9'h03F, 9'h03F}));
    chk("rst_wrap",  32'(ifa.wrap), 32'h0);
    chk("rst_err",   32'(ifa.load_err), 32'h0);
    rst_n = 1'b1;

    // Up count on A: first step at edge 4, then every 4 edges, 09 -> 10
    ifa.en = 1; ifa.dir = 1;
    for (int n = 1; n <= 40; n++) begin
      edge1();
      chk("a_up", 32'(ifa.count), 32'(to_bcd(n / 4)));
    end
    chk("a_seg10", 32'(ifa.seg_led), 32'({9'h006, 9'h03F}));

    // en low for 3 cycles mid-period stretches the step by 3
    repeat (2) edge1();
    chk("a_hold0", 32'(ifa.count), 32'h10);
    ifa.en = 0;
    repeat (3) edge1();
    chk("a_hold1", 32'(ifa.count), 32'h10);
    ifa.en = 1;
    edge1();
    chk("a_hold2", 32'(ifa.count), 32'h10);
    edge1();
    chk("a_step7", 32'(ifa.count), 32'h11);

    // Down from 10 through 00 to 99 with a single-cycle wrap
    ifa.en = 0; ifa.load = 1; ifa.load_val = 8'h10;
    edge1();
    chk("a_load10", 32'(ifa.count), 32'h10);
    ifa.load = 0; ifa.en = 1; ifa.dir = 0;
    for (int n = 1; n <= 44; n++) begin
      edge1();
      chk("a_dn", 32'(ifa.count), 32'((n == 44) ? 8'h99 : to_bcd(10 - n / 4)));
      chk("a_dn_wrap", 32'(ifa.wrap), 32'(n == 44));
    end
    repeat (3) begin
      edge1();
      chk("a_wrap_off", 32'(ifa.wrap), 32'h0);
    end

    // clr + load + tick in the same cycle: clear wins, tick discarded
    ifa.clr = 1; ifa.load = 1; ifa.load_val = 8'h47;
    edge1();
    chk("a_clr_cnt",  32'(ifa.count), 32'h00);
    chk("a_clr_wrap", 32'(ifa.wrap), 32'h0);
    chk("a_clr_err",  32'(ifa.load_err), 32'h0);
    ifa.clr = 0; ifa.load = 0; ifa.dir = 1;
    repeat (3) edge1();
    chk("a_clr_pre", 32'(ifa.count), 32'h00);
    edge1();
    chk("a_clr_step", 32'(ifa.count), 32'h01);

    // B: MAX_BCD = 59, 58 -> 59 -> 00 (wrap) -> 01
    ifb.load = 1; ifb.load_val = 8'h58;
    edge1();
    chk("b_load58", 32'(ifb.count), 32'h58);
    ifb.load = 0; ifb.en = 1; ifb.dir = 1;
    for (int n = 1; n <= 12; n++) begin
      edge1();
      chk("b_up", 32'(ifb.count),
          32'((n < 4) ? 8'h58 : (n < 8) ? 8'h59 : (n < 12) ? 8'h00 : 8'h01));
      chk("b_wrap", 32'(ifb.wrap), 32'(n == 8));
    end
    ifb.en = 0; ifb.load = 1; ifb.load_val = 8'h60;
    edge1();
    chk("b_ld60_err", 32'(ifb.load_err), 32'h1);
    chk("b_ld60_cnt", 32'(ifb.count), 32'h01);
    ifb.load = 0;
    edge1();
    chk("b_err_off", 32'(ifb.load_err), 32'h0);
    ifb.load = 1; ifb.load_val = 8'h59;
    edge1();
    chk("b_ld59_cnt", 32'(ifb.count), 32'h59);
    chk("b_ld59_err", 32'(ifb.load_err), 32'h0);
    ifb.load = 0;

    // C: TICK_DIV = 1, one vector per cycle
    for (int i = 0; i < 16; i++) begin
      {ifc.en, ifc.dir, ifc.clr, ifc.load} = tv[i].ctl;
      ifc.load_val = tv[i].lv;
      edge1();
      chk($sformatf("c_cnt[%0d]", i),  32'(ifc.count), 32'(tv[i].ecount));
      chk($sformatf("c_wrap[%0d]", i), 32'(ifc.wrap), 32'(tv[i].ev[1]));
      chk($sformatf("c_err[%0d]", i),  32'(ifc.load_err), 32'(tv[i].ev[0]));
      chk($sformatf("c_seg[%0d]", i),  32'(ifc.seg_led), 32'(ref_seg2(tv[i].ecount)));
    end
    ifc.en = 0; ifc.clr = 0; ifc.load = 0;

    // Asynchronous reset mid-period at count 37
    ifa.en = 0; ifa.load = 1; ifa.load_val = 8'h37;
    edge1();
    chk("a_load37", 32'(ifa.count), 32'h37);
    ifa.load = 0; ifa.en = 1; ifa.dir = 1;
    repeat (2) edge1();
    #2 rst_n = 1'b0;
    #1;
    chk("ar_count", 32'(ifa.count), 32'h00);
    chk("ar_seg",   32'(ifa.seg_led), 32'({9'h03F, 9'h03F}));
    chk("ar_wrap",  32'(ifa.wrap), 32'h0);
    edge1();
    chk("ar_hold", 32'(ifa.count), 32'h00);
    rst_n = 1'b1;
    repeat (3) edge1();
    chk("ar_pre", 32'(ifa.count), 32'h00);
    edge1();
    chk("ar_step", 32'(ifa.count), 32'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
